// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: FSM encoding and issue latency.
package mul_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Cycles from an accepting edge to the next accepting edge; issue logic spaces multiplies by this.
  function automatic int mul_lat(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/mul_seq_dp.sv
// Shift-add datapath: multiplicand, split accumulator, (WIDTH+1)-bit adder and product registers.
module mul_seq_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             commit,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_hi_nx;
  logic [WIDTH-1:0] acc_lo_nx;

  // The adder carry lands in acc_hi's MSB after the shift, so the product never overflows.
  always_comb begin
    sum       = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    acc_hi_nx = sum[WIDTH:1];
    acc_lo_nx = {sum[0], acc_lo[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m       <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
    end else begin
      if (load) begin
        m      <= a;
        acc_hi <= '0;
        acc_lo <= b;
      end else if (step) begin
        acc_hi <= acc_hi_nx;
        acc_lo <= acc_lo_nx;
      end
      // Commit coincides with the final step, so it captures the post-step accumulator.
      if (commit) begin
        prod_hi <= acc_hi_nx;
        prod_lo <= acc_lo_nx;
      end
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the unsigned shift-add multiplier: start/abort handshake, step counter, busy/done.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mul_state_t       state;
  mul_state_t       state_nx;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             commit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RUN);
      done  <= (state_nx == DONE);
      if (load)
        cnt <= '0;
      else if (step)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == LAST_STEP) begin
            commit   = 1'b1;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        // Back-to-back accept keeps the issue rate at one multiply per WIDTH+1 cycles.
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  mul_seq_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .commit (commit),
    .a      (a),
    .b      (b),
    .prod_hi(prod_hi),
    .prod_lo(prod_lo)
  );

endmodule
